// File: rtl/pipeline_pkg.sv
// Shared types for the MIPS pipeline control logic: register index width,
// hazard FSM states and stall-cause encoding.
package pipeline_pkg;

  localparam int REG_W = 5;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    NONE       = 3'd0,
    LOAD_USE   = 3'd1,
    BR_ALU     = 3'd2,
    BR_LOAD    = 3'd3,
    BR_MEMLOAD = 3'd4
  } cause_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational register-index compare between ID and the EX/MEM producers;
// yields the stall length needed and its cause.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_W = pipeline_pkg::REG_W
) (
  input  logic             id_ex_memread_i,
  input  logic             id_ex_regwrite_i,
  input  logic [REG_W-1:0] id_ex_dst_i,
  input  logic             ex_mem_memread_i,
  input  logic [REG_W-1:0] ex_mem_dst_i,
  input  logic [REG_W-1:0] if_id_rs_i,
  input  logic [REG_W-1:0] if_id_rt_i,
  input  logic             if_id_uses_rt_i,
  input  logic             if_id_branch_i,
  output logic [1:0]       need_o,
  output cause_t           cause_o
);

  logic ex_hit_s;
  logic mem_hit_s;

  // $zero is never a real dependency, so dst == 0 never matches
  assign ex_hit_s  = (id_ex_dst_i != {REG_W{1'b0}}) &&
                     ((id_ex_dst_i == if_id_rs_i) ||
                      (if_id_uses_rt_i && (id_ex_dst_i == if_id_rt_i)));
  assign mem_hit_s = (ex_mem_dst_i != {REG_W{1'b0}}) &&
                     ((ex_mem_dst_i == if_id_rs_i) ||
                      (if_id_uses_rt_i && (ex_mem_dst_i == if_id_rt_i)));

  // Priority chain ordered so the longest applicable stall wins
  always_comb begin
    need_o  = 2'd0;
    cause_o = NONE;
    if (if_id_branch_i && id_ex_memread_i && ex_hit_s) begin
      need_o  = 2'd2;
      cause_o = BR_LOAD;
    end else if (!if_id_branch_i && id_ex_memread_i && ex_hit_s) begin
      need_o  = 2'd1;
      cause_o = LOAD_USE;
    end else if (if_id_branch_i && id_ex_regwrite_i && !id_ex_memread_i && ex_hit_s) begin
      need_o  = 2'd1;
      cause_o = BR_ALU;
    end else if (if_id_branch_i && ex_mem_memread_i && mem_hit_s) begin
      need_o  = 2'd1;
      cause_o = BR_MEMLOAD;
    end else begin
      need_o  = 2'd0;
      cause_o = NONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall FSM, IF/ID flush and stall/flush counters.
// Optional feature macro: HAZARD_PERF_EN (performance counters).
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W = pipeline_pkg::REG_W,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_ex_memread_i,
  input  logic             id_ex_regwrite_i,
  input  logic [REG_W-1:0] id_ex_dst_i,
  input  logic             ex_mem_memread_i,
  input  logic [REG_W-1:0] ex_mem_dst_i,
  input  logic [REG_W-1:0] if_id_rs_i,
  input  logic [REG_W-1:0] if_id_rt_i,
  input  logic             if_id_uses_rt_i,
  input  logic             if_id_branch_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] cnt_r;
  logic [1:0] cnt_nxt_s;
  logic [1:0] need_s;
  cause_t     cause_s;
  logic       stall_s;
  logic       flush_s;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_detect (
    .id_ex_memread_i  (id_ex_memread_i),
    .id_ex_regwrite_i (id_ex_regwrite_i),
    .id_ex_dst_i      (id_ex_dst_i),
    .ex_mem_memread_i (ex_mem_memread_i),
    .ex_mem_dst_i     (ex_mem_dst_i),
    .if_id_rs_i       (if_id_rs_i),
    .if_id_rt_i       (if_id_rt_i),
    .if_id_uses_rt_i  (if_id_uses_rt_i),
    .if_id_branch_i   (if_id_branch_i),
    .need_o           (need_s),
    .cause_o          (cause_s)
  );

  // FSM state and remaining-hold counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= RUN;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next state plus raw stall/flush decisions; HOLD ignores hazard inputs
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (need_s != 2'd0) begin
          stall_s = 1'b1;
          if (cause_s == BR_LOAD) begin
            state_nxt_s = HOLD;
            cnt_nxt_s   = 2'd1;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          flush_s = branch_taken_i;
        end
      end
      HOLD: begin
        stall_s   = 1'b1;
        cnt_nxt_s = cnt_r - 2'd1;
        if (cnt_r <= 2'd1) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = 2'd0;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = 2'd0;
      end
    endcase
  end

  // Output decode; reset forces the pipeline-running values immediately
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    if (rst_i) begin
      ifid_flush_o = 1'b0;
    end else if (stall_s) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else begin
      ifid_flush_o = flush_s;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating stall-cycle and flush counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;
`else
  assign stall_cnt_o = {CNT_W{1'b0}};
  assign flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic
// against a stall-budget reference model.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             id_ex_memread_i;
  logic             id_ex_regwrite_i;
  logic [REG_W-1:0] id_ex_dst_i;
  logic             ex_mem_memread_i;
  logic [REG_W-1:0] ex_mem_dst_i;
  logic [REG_W-1:0] if_id_rs_i;
  logic [REG_W-1:0] if_id_rt_i;
  logic             if_id_uses_rt_i;
  logic             if_id_branch_i;
  logic             branch_taken_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .id_ex_memread_i  (id_ex_memread_i),
    .id_ex_regwrite_i (id_ex_regwrite_i),
    .id_ex_dst_i      (id_ex_dst_i),
    .ex_mem_memread_i (ex_mem_memread_i),
    .ex_mem_dst_i     (ex_mem_dst_i),
    .if_id_rs_i       (if_id_rs_i),
    .if_id_rt_i       (if_id_rt_i),
    .if_id_uses_rt_i  (if_id_uses_rt_i),
    .if_id_branch_i   (if_id_branch_i),
    .branch_taken_i   (branch_taken_i),
    .pc_write_o       (pc_write_o),
    .ifid_write_o     (ifid_write_o),
    .ifid_flush_o     (ifid_flush_o),
    .idex_bubble_o    (idex_bubble_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int     n_chk = 0;
  int     n_pass = 0;
  int     hold_left = 0;
  longint m_stall = 0;
  longint m_flush = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic bit hit(input logic [REG_W-1:0] dst);
    return (dst != 0) && ((dst == if_id_rs_i) || (if_id_uses_rt_i && (dst == if_id_rt_i)));
  endfunction

  // Largest stall requested by any applicable hazard rule
  function automatic int need_of();
    int n = 0;
    if (if_id_branch_i && id_ex_memread_i && hit(id_ex_dst_i)) n = 2;
    if (!if_id_branch_i && id_ex_memread_i && hit(id_ex_dst_i) && n < 1) n = 1;
    if (if_id_branch_i && id_ex_regwrite_i && !id_ex_memread_i && hit(id_ex_dst_i) && n < 1) n = 1;
    if (if_id_branch_i && ex_mem_memread_i && hit(ex_mem_dst_i) && n < 1) n = 1;
    return n;
  endfunction

  task automatic set_in(input bit mr, input bit rw, input int dst, input bit mm, input int mdst,
                        input int rs, input int rt, input bit urt, input bit br, input bit tk);
    id_ex_memread_i  = mr;
    id_ex_regwrite_i = rw;
    id_ex_dst_i      = REG_W'(dst);
    ex_mem_memread_i = mm;
    ex_mem_dst_i     = REG_W'(mdst);
    if_id_rs_i       = REG_W'(rs);
    if_id_rt_i       = REG_W'(rt);
    if_id_uses_rt_i  = urt;
    if_id_branch_i   = br;
    branch_taken_i   = tk;
  endtask

  task automatic check_outs(input string tag, input bit stall, input bit flush);
    chk({tag, "_pcw"},   pc_write_o,    !stall);
    chk({tag, "_ifidw"}, ifid_write_o,  !stall);
    chk({tag, "_bub"},   idex_bubble_o, stall);
    chk({tag, "_flush"}, ifid_flush_o,  flush);
`ifdef HAZARD_PERF_EN
    chk({tag, "_scnt"}, stall_cnt_o, m_stall);
    chk({tag, "_fcnt"}, flush_cnt_o, m_flush);
`else
    chk({tag, "_scnt"}, stall_cnt_o, 0);
    chk({tag, "_fcnt"}, flush_cnt_o, 0);
`endif
  endtask

  // One clock: check at negedge against the model, then advance the model
  task automatic cycle(input string tag);
    int  n = 0;
    bit  stall;
    bit  flush;
    @(negedge clk_i);
    if (hold_left > 0) begin
      stall = 1'b1;
      flush = 1'b0;
    end else begin
      n     = need_of();
      stall = (n > 0);
      flush = (n == 0) && branch_taken_i;
    end
    check_outs(tag, stall, flush);
    @(posedge clk_i);
    if (hold_left > 0) hold_left--;
    else if (n > 0) hold_left = n - 1;
    m_stall += longint'(stall);
    m_flush += longint'(flush);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    set_in(1, 1, 8, 0, 0, 8, 0, 0, 0, 0);
    #1;
    check_outs("reset", 1'b0, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #1;

    set_in(1, 1, 8, 0, 0, 8, 3, 1, 0, 0);   // lw $8 ; add uses $8
    cycle("lu");
    set_in(0, 0, 0, 1, 8, 8, 3, 1, 0, 0);
    cycle("lu_after");

    set_in(1, 1, 9, 0, 0, 4, 9, 1, 1, 0);   // lw $9 ; beq uses $9
    cycle("bl1");
    set_in(0, 0, 0, 1, 9, 4, 9, 1, 1, 0);   // bubble in EX, load now in MEM
    cycle("bl2");
    set_in(0, 0, 0, 0, 0, 4, 9, 1, 1, 1);
    cycle("bl3");

    set_in(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle("zero");

    set_in(0, 0, 0, 0, 0, 1, 2, 1, 1, 1);
    cycle("tk");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("tk_after");

    set_in(0, 1, 5, 0, 0, 5, 0, 0, 1, 1);   // ALU write to $5 ; taken beq on $5
    cycle("sim1");
    set_in(0, 0, 0, 0, 0, 5, 0, 0, 1, 1);
    cycle("sim2");

    set_in(1, 1, 9, 0, 0, 9, 0, 0, 1, 0);
    cycle("rs1");
    rst_i = 1'b1;
    #1;
    hold_left = 0;
    m_stall   = 0;
    m_flush   = 0;
    check_outs("rs_mid", 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #1;
    cycle("rs_after");

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1));
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
